// File: rtl/bcd_sub_serial_if.sv
// Handshake bundle for the digit-serial packed-BCD subtractor.
// The operand side uses in_valid/in_ready and the result side uses out_valid/out_ready.
interface bcd_sub_serial_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   diff;
  logic                  borrow;
  logic                  invalid;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, invalid
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, invalid
  );
endinterface

// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor: diff = a - b, one digit per clock, least-significant digit first.
// Operands with a nibble above 9 produce a zero result with the invalid flag set, after the same latency.
module bcd_sub_serial #(
  parameter int DIGITS = 4,
  parameter int CW     = 4
) (
  input  logic               clk,
  input  logic               rst,
  bcd_sub_serial_if.slave    bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    res_q;
  logic [CW-1:0]   idx_q;
  logic            br_q;
  logic            inv_q;
  logic            out_valid_q;
  logic [W-1:0]    diff_q;
  logic            borrow_q;
  logic            invalid_q;

  logic [4:0]      t_d;
  logic [3:0]      dig_d;
  logic            br_d;
  logic [W-1:0]    res_d;
  logic            last_d;

  // True when any nibble of v lies outside 0..9.
  function automatic logic has_bad_nibble(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (v[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // Current digit sits in the low nibble of the operand shift registers.
  always_comb begin
    t_d    = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'd0, br_q};
    br_d   = t_d[4];
    if (t_d[4]) begin
      dig_d = 4'(t_d + 5'd10);
    end else begin
      dig_d = t_d[3:0];
    end
    res_d  = (res_q >> 4) | (W'(dig_d) << (W - 4));
    last_d = (idx_q == CW'(DIGITS - 1));
  end

  // Control FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      br_q        <= 1'b0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            inv_q   <= has_bad_nibble(bus.a) | has_bad_nibble(bus.b);
            idx_q   <= '0;
            br_q    <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          res_q <= res_d;
          br_q  <= br_d;
          idx_q <= idx_q + CW'(1);
          if (last_d) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            invalid_q   <= inv_q;
            diff_q      <= inv_q ? '0 : res_d;
            borrow_q    <= inv_q ? 1'b0 : br_d;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.invalid   = invalid_q;
endmodule

// File: tb/tb_bcd_sub_serial.sv
// Directed self-checking bench for bcd_sub_serial (DIGITS=4); inputs change and outputs are sampled on the falling edge.
module tb_bcd_sub_serial;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  bcd_sub_serial_if #(.DIGITS(4)) bus ();

  bcd_sub_serial #(.DIGITS(4), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accept one operand pair, check the fixed 4-cycle latency, then check the held result.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] ed,
                       input logic eb, input logic ei, input string tag);
    chk({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_lat_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_lat_in_ready"}, 32'(bus.in_ready), 32'd0);
      if (k < 3) step();
    end
    step();
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_diff"}, 32'(bus.diff), 32'(ed));
    chk({tag, "_borrow"}, 32'(bus.borrow), 32'(eb));
    chk({tag, "_invalid"}, 32'(bus.invalid), 32'(ei));
  endtask

  task automatic finish_op(input string tag);
    bus.out_ready = 1'b1;
    step();
    chk({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.out_ready = 1'b1;
    @(negedge clk);
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_borrow", 32'(bus.borrow), 32'd0);
    chk("rst_invalid", 32'(bus.invalid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic subtraction; out_valid is high for exactly one cycle with out_ready held.
    do_op(16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, "t1");
    finish_op("t1");

    do_op(16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0, "t2a");
    finish_op("t2a");
    do_op(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, "t2b");
    finish_op("t2b");

    do_op(16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, "t3a");
    finish_op("t3a");
    do_op(16'h0000, 16'h9999, 16'h0001, 1'b1, 1'b0, "t3b");
    finish_op("t3b");

    // Back-pressure: result held, new operands refused.
    bus.out_ready = 1'b0;
    do_op(16'h0042, 16'h0017, 16'h0025, 1'b0, 1'b0, "t4");
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = k[0] ? 1'b0 : 1'b1;
      bus.a        = 16'h9999;
      bus.b        = 16'h0000;
      step();
      chk("t4_hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_diff", 32'(bus.diff), 32'h0025);
      chk("t4_hold_borrow", 32'(bus.borrow), 32'd0);
      chk("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    finish_op("t4");
    chk("t4_idle_diff_kept", 32'(bus.diff), 32'h0025);
    do_op(16'h0500, 16'h0123, 16'h0377, 1'b0, 1'b0, "t4n");
    finish_op("t4n");

    do_op(16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, "t5a");
    finish_op("t5a");
    do_op(16'h0100, 16'h0099, 16'h0001, 1'b0, 1'b0, "t5b");
    finish_op("t5b");

    // Reset during the second CALC cycle abandons the operation.
    bus.in_valid = 1'b1;
    bus.a        = 16'h0777;
    bus.b        = 16'h0111;
    step();
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_diff", 32'(bus.diff), 32'd0);
    chk("t6_rst_borrow", 32'(bus.borrow), 32'd0);
    chk("t6_rst_invalid", 32'(bus.invalid), 32'd0);
    rst = 1'b0;
    step();
    chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_no_output", 32'(bus.out_valid), 32'd0);
    end
    do_op(16'h0050, 16'h0025, 16'h0025, 1'b0, 1'b0, "t6");
    finish_op("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
